disp_rdarb: RTL and testbench



---
 rtl/disp_rdarb.sv | 166 ++++++++++++++++
 tb/tb_disp_rdarb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_rdarb.sv
// Two-requester AXI4 read arbiter for the display read master: one burst in flight,
// urgent-override plus round-robin grant, R-channel routing and sticky burst checks.
module disp_rdarb #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                          ACLK,
  input  logic                          ARST,

  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]                    S0_ARLEN,
  input  logic                          S0_ARVALID,
  output logic                          S0_ARREADY,
  input  logic                          S0_URGENT,
  output logic                          S0_RVALID,
  output logic                          S0_RLAST,
  input  logic                          S0_RREADY,

  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]                    S1_ARLEN,
  input  logic                          S1_ARVALID,
  output logic                          S1_ARREADY,
  output logic                          S1_RVALID,
  output logic                          S1_RLAST,
  input  logic                          S1_RREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0] RDATA_OUT,

  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,

  input  logic                          ERRCLR,
  output logic                          LEN_ERR,
  output logic                          RESP_ERR,
  output logic                          GRANT
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                        state_q, state_d;
  logic                          grant_q, grant_d;
  logic                          last_q, last_d;     // round-robin pointer, separate from GRANT
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                    arlen_q, arlen_d;
  logic [8:0]                    beat_cnt_q, beat_cnt_d;
  logic                          len_err_q, len_err_d;
  logic                          resp_err_q, resp_err_d;

  logic s0_win, s1_win;
  logic sel_rready;
  logic beat_acc;
  logic len_mismatch;

  // Urgency only matters when requester 0 is actually asking.
  always_comb begin
    s0_win = S0_ARVALID & (S0_URGENT | ~S1_ARVALID | last_q);
    s1_win = S1_ARVALID & ~s0_win;
  end

  assign sel_rready   = grant_q ? S1_RREADY : S0_RREADY;
  assign beat_acc     = (state_q == StData) & M_AXI_RVALID & sel_rready;
  assign len_mismatch = (({1'b0, beat_cnt_q}) + 10'd1) != (({2'b00, arlen_q}) + 10'd1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    beat_cnt_d    = beat_cnt_q;
    len_err_d     = ERRCLR ? 1'b0 : len_err_q;
    resp_err_d    = ERRCLR ? 1'b0 : resp_err_q;
    S0_ARREADY    = 1'b0;
    S1_ARREADY    = 1'b0;
    S0_RVALID     = 1'b0;
    S0_RLAST      = 1'b0;
    S1_RVALID     = 1'b0;
    S1_RLAST      = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;

    case (state_q)
      StIdle: begin
        if (s0_win || s1_win) begin
          S0_ARREADY = s0_win;
          S1_ARREADY = s1_win;
          araddr_d   = s1_win ? S1_ARADDR : S0_ARADDR;
          arlen_d    = s1_win ? S1_ARLEN : S0_ARLEN;
          grant_d    = s1_win;
          last_d     = s1_win;
          beat_cnt_d = 9'd0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = StData;
        end
      end
      StData: begin
        M_AXI_RREADY = sel_rready;
        if (grant_q) begin
          S1_RVALID = M_AXI_RVALID;
          S1_RLAST  = M_AXI_RLAST;
        end else begin
          S0_RVALID = M_AXI_RVALID;
          S0_RLAST  = M_AXI_RLAST;
        end
        if (beat_acc) begin
          if (beat_cnt_q != 9'h1FF) begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
          // Error set takes priority over a same-cycle ERRCLR.
          if (M_AXI_RRESP != 2'b00) begin
            resp_err_d = 1'b1;
          end
          if (M_AXI_RLAST) begin
            if (len_mismatch) begin
              len_err_d = 1'b1;
            end
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      araddr_q   <= '0;
      arlen_q    <= 8'd0;
      beat_cnt_q <= 9'd0;
      len_err_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign M_AXI_ARADDR = araddr_q;
  assign M_AXI_ARLEN  = arlen_q;
  assign RDATA_OUT    = M_AXI_RDATA;
  assign LEN_ERR      = len_err_q;
  assign RESP_ERR     = resp_err_q;
  assign GRANT        = grant_q;

endmodule

// File: tb/tb_disp_rdarb.sv
// Directed bench for disp_rdarb: table of whole bursts plus hand-written backpressure
// and mid-burst reset sequences, with a behavioural AXI slave driven inline.
module tb_disp_rdarb;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam logic [8:0] NONE = 9'h1FF;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic          ACLK = 1'b0;
  logic          ARST;
  logic [AW-1:0] S0_ARADDR, S1_ARADDR;
  logic [7:0]    S0_ARLEN, S1_ARLEN;
  logic          S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY, S0_URGENT;
  logic          S0_RVALID, S0_RLAST, S0_RREADY, S1_RVALID, S1_RLAST, S1_RREADY;
  logic [DW-1:0] RDATA_OUT;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic          ERRCLR, LEN_ERR, RESP_ERR, GRANT;

  disp_rdarb #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID),
    .S0_ARREADY(S0_ARREADY), .S0_URGENT(S0_URGENT), .S0_RVALID(S0_RVALID),
    .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID),
    .S1_ARREADY(S1_ARREADY), .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST),
    .S1_RREADY(S1_RREADY),
    .RDATA_OUT(RDATA_OUT),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .ERRCLR(ERRCLR), .LEN_ERR(LEN_ERR), .RESP_ERR(RESP_ERR), .GRANT(GRANT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic       s0v;
    logic       s1v;
    logic       urg;
    logic [7:0] arlen;
    logic [8:0] nbeats;
    logic [8:0] resp_beat;
    logic       clr_last;
    logic       exp_grant;
    logic       exp_len_err;
    logic       exp_resp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s0v, input logic s1v, input logic urg,
                              input logic [7:0] arlen, input logic [8:0] nbeats,
                              input logic [8:0] resp_beat, input logic clr_last,
                              input logic g, input logic le, input logic re);
    vec_t v;
    v = '{s0v, s1v, urg, arlen, nbeats, resp_beat, clr_last, g, le, re};
    return v;
  endfunction

  // One full transaction: request, address handshake, data beats, error check, ERRCLR.
  task automatic run_burst(input vec_t v);
    logic [63:0] d;
    logic        last;
    @(posedge ACLK); #1;
    S0_ARVALID = v.s0v;
    S1_ARVALID = v.s1v;
    S0_URGENT  = v.urg;
    S0_ARLEN   = v.exp_grant ? 8'hEE : v.arlen;
    S1_ARLEN   = v.exp_grant ? v.arlen : 8'hEE;
    S0_RREADY  = 1'b1;
    S1_RREADY  = 1'b1;
    @(negedge ACLK);
    chk("s0_arready", S0_ARREADY, !v.exp_grant);
    chk("s1_arready", S1_ARREADY, v.exp_grant);
    chk("idle_m_arvalid", M_AXI_ARVALID, 1'b0);
    @(posedge ACLK); #1;
    S0_ARVALID    = 1'b0;
    S1_ARVALID    = 1'b0;
    S0_URGENT     = 1'b0;
    M_AXI_ARREADY = 1'b1;
    @(negedge ACLK);
    chk("m_arvalid", M_AXI_ARVALID, 1'b1);
    chk("m_araddr", M_AXI_ARADDR, v.exp_grant ? A1 : A0);
    chk("m_arlen", M_AXI_ARLEN, v.arlen);
    chk("grant", GRANT, v.exp_grant);
    @(posedge ACLK); #1;
    M_AXI_ARREADY = 1'b0;
    for (int i = 0; i < int'(v.nbeats); i++) begin
      d            = 64'hCAFE_0000_0000_0000 | 64'(i);
      last         = (i == int'(v.nbeats) - 1);
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = d;
      M_AXI_RLAST  = last;
      M_AXI_RRESP  = (i == int'(v.resp_beat)) ? 2'b10 : 2'b00;
      ERRCLR       = v.clr_last & last;
      @(negedge ACLK);
      chk("gnt_rvalid", v.exp_grant ? S1_RVALID : S0_RVALID, 1'b1);
      chk("oth_rvalid", v.exp_grant ? S0_RVALID : S1_RVALID, 1'b0);
      chk("gnt_rlast", v.exp_grant ? S1_RLAST : S0_RLAST, last);
      chk("oth_rlast", v.exp_grant ? S0_RLAST : S1_RLAST, 1'b0);
      chk("rdata", RDATA_OUT, d);
      @(posedge ACLK); #1;
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
    ERRCLR       = 1'b0;
    @(negedge ACLK);
    chk("idle_rready", M_AXI_RREADY, 1'b0);
    chk("len_err", LEN_ERR, v.exp_len_err);
    chk("resp_err", RESP_ERR, v.exp_resp_err);
    @(posedge ACLK); #1;
    ERRCLR = 1'b1;
    @(posedge ACLK); #1;
    ERRCLR = 1'b0;
    @(negedge ACLK);
    chk("clr_len_err", LEN_ERR, 1'b0);
    chk("clr_resp_err", RESP_ERR, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b, got, cyc;
    ARST = 1'b1;
    S0_ARADDR = A0; S1_ARADDR = A1; S0_ARLEN = 8'd0; S1_ARLEN = 8'd0;
    S0_ARVALID = 1'b0; S1_ARVALID = 1'b0; S0_URGENT = 1'b0;
    S0_RREADY = 1'b0; S1_RREADY = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0; ERRCLR = 1'b0;

    //          s0 s1 ur arlen  nbeats resp   clr g  le re
    vecs[0]  = mk(1, 1, 0, 8'd1,  9'd2,  NONE,  0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 8'd1,  9'd2,  NONE,  0, 1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 8'd1,  9'd2,  NONE,  0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 8'd1,  9'd2,  NONE,  0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 8'd0,  9'd1,  NONE,  0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 8'd1,  9'd2,  NONE,  0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 8'd1,  9'd2,  NONE,  0, 1, 0, 0);
    vecs[7]  = mk(1, 0, 0, 8'd15, 9'd16, NONE,  0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 8'd15, 9'd8,  NONE,  0, 1, 1, 0);
    vecs[9]  = mk(1, 0, 0, 8'd3,  9'd4,  9'd2,  0, 0, 0, 1);
    vecs[10] = mk(0, 1, 1, 8'd2,  9'd3,  NONE,  0, 1, 0, 0);
    vecs[11] = mk(1, 0, 0, 8'd0,  9'd1,  9'd0,  1, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, 8'd3,  9'd5,  NONE,  0, 0, 1, 0);

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_grant", GRANT, 1'b0);
    chk("rst_m_arvalid", M_AXI_ARVALID, 1'b0);
    chk("rst_m_rready", M_AXI_RREADY, 1'b0);
    chk("rst_araddr", M_AXI_ARADDR, 32'h0);
    chk("rst_arlen", M_AXI_ARLEN, 8'h0);
    chk("rst_len_err", LEN_ERR, 1'b0);
    chk("rst_resp_err", RESP_ERR, 1'b0);
    #1 ARST = 1'b0;

    for (int k = 0; k < 13; k++) run_burst(vecs[k]);

    // Backpressure on requester 1: RREADY toggles while RVALID is held.
    @(posedge ACLK); #1;
    S1_ARVALID = 1'b1; S1_ARLEN = 8'd15; S0_RREADY = 1'b1; S1_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S1_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
    @(posedge ACLK); #1;
    M_AXI_ARREADY = 1'b0;
    b = 0; got = 0; cyc = 0;
    while (b < 16 && cyc < 64) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 64'hBEEF_0000_0000_0000 | 64'(b);
      M_AXI_RLAST  = (b == 15);
      S1_RREADY    = cyc[0];
      @(negedge ACLK);
      chk("bp_mirror", M_AXI_RREADY, S1_RREADY);
      chk("bp_rvalid", S1_RVALID, 1'b1);
      if (S1_RREADY) begin
        chk("bp_rdata", RDATA_OUT, 64'hBEEF_0000_0000_0000 | 64'(b));
        got++;
      end
      @(posedge ACLK); #1;
      if (S1_RREADY) b++;
      cyc++;
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    chk("bp_beats", got, 16);
    @(negedge ACLK);
    chk("bp_idle_rready", M_AXI_RREADY, 1'b0);
    chk("bp_len_err", LEN_ERR, 1'b0);

    // Reset in DATA after 5 beats (first beat flagged so RESP_ERR is set beforehand).
    @(posedge ACLK); #1;
    S1_ARVALID = 1'b1; S1_ARLEN = 8'd15; S0_RREADY = 1'b1; S1_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S1_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
    @(posedge ACLK); #1;
    M_AXI_ARREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RRESP  = (i == 0) ? 2'b10 : 2'b00;
      @(posedge ACLK); #1;
    end
    M_AXI_RRESP = 2'b00;
    @(negedge ACLK);
    chk("pre_rst_grant", GRANT, 1'b1);
    chk("pre_rst_resp_err", RESP_ERR, 1'b1);
    chk("pre_rst_rvalid", S1_RVALID, 1'b1);
    @(posedge ACLK); #1;
    ARST = 1'b1;
    @(posedge ACLK); #1;
    ARST = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_grant", GRANT, 1'b0);
    chk("mid_rst_m_arvalid", M_AXI_ARVALID, 1'b0);
    chk("mid_rst_m_rready", M_AXI_RREADY, 1'b0);
    chk("mid_rst_s1_rvalid", S1_RVALID, 1'b0);
    chk("mid_rst_s0_rvalid", S0_RVALID, 1'b0);
    chk("mid_rst_araddr", M_AXI_ARADDR, 32'h0);
    chk("mid_rst_arlen", M_AXI_ARLEN, 8'h0);
    chk("mid_rst_resp_err", RESP_ERR, 1'b0);
    #1 M_AXI_RVALID = 1'b0;

    // After reset the tie goes to requester 0, then round-robin resumes.
    run_burst(mk(1, 1, 0, 8'd1, 9'd2, NONE, 0, 0, 0, 0));
    run_burst(mk(1, 1, 0, 8'd1, 9'd2, NONE, 0, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
